// File: rtl/alu_ex_unit.sv
// Registered ALU execute stage with valid/ready handshake on both sides.
// Define ALU_SERIAL_SHIFT_EN to build a one-bit-per-cycle shifter instead of the barrel shifter.
module alu_ex_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              BrTaken
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1100;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1110;
    localparam logic [3:0] OP_BLT = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                br_q, br_d;

    logic [4:0]          shamt;
    logic                lt_signed;
    logic                accept;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_br;

    assign shamt     = SrcB[4:0];
    assign lt_signed = $signed(SrcA) < $signed(SrcB);

    // The reset term keeps in_ready low during the reset cycle itself.
    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready) && !flush && !reset;
    assign accept    = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign BrTaken   = br_q;

    always_comb begin
        alu_res = '0;
        alu_br  = 1'b0;
        case (Operation)
            OP_AND: alu_res = SrcA & SrcB;
            OP_OR:  alu_res = SrcA | SrcB;
            OP_ADD: alu_res = SrcA + SrcB;
            OP_SUB: alu_res = SrcA - SrcB;
            OP_SLL: alu_res = SrcA << shamt;
            OP_SRL: alu_res = SrcA >> shamt;
            OP_SRA: alu_res = $unsigned($signed(SrcA) >>> shamt);
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, lt_signed};
            OP_BEQ: alu_br  = (SrcA == SrcB);
            OP_BNE: alu_br  = (SrcA != SrcB);
            OP_BLT: alu_br  = lt_signed;
            default: begin
                alu_res = '0;
                alu_br  = 1'b0;
            end
        endcase
    end

`ifdef ALU_SERIAL_SHIFT_EN
    logic [DATA_W-1:0]   shift_val_q, shift_val_d;
    logic [4:0]          shift_cnt_q, shift_cnt_d;
    logic [3:0]          shift_op_q, shift_op_d;
    logic [DATA_W-1:0]   shift_step;
    logic                is_shift;

    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

    always_comb begin
        case (shift_op_q)
            OP_SLL:  shift_step = shift_val_q << 1;
            OP_SRL:  shift_step = shift_val_q >> 1;
            default: shift_step = {shift_val_q[DATA_W-1], shift_val_q[DATA_W-1:1]};
        endcase
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        br_d        = br_q;
`ifdef ALU_SERIAL_SHIFT_EN
        shift_val_d = shift_val_q;
        shift_cnt_d = shift_cnt_q;
        shift_op_d  = shift_op_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_SERIAL_SHIFT_EN
                    if (is_shift && (shamt != 5'd0)) begin
                        state_d     = SHIFT;
                        shift_val_d = SrcA;
                        shift_cnt_d = shamt;
                        shift_op_d  = Operation;
                    end else begin
                        result_d    = alu_res;
                        br_d        = alu_br;
                        out_valid_d = 1'b1;
                    end
`else
                    result_d    = alu_res;
                    br_d        = alu_br;
                    out_valid_d = 1'b1;
`endif
                end
            end
            SHIFT: begin
`ifdef ALU_SERIAL_SHIFT_EN
                // The last step writes straight into the result register so it lands exactly k cycles later.
                shift_val_d = shift_step;
                shift_cnt_d = shift_cnt_q - 5'd1;
                if (shift_cnt_q == 5'd1) begin
                    result_d    = shift_step;
                    br_d        = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
            shift_cnt_d = 5'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            br_q        <= 1'b0;
`ifdef ALU_SERIAL_SHIFT_EN
            shift_val_q <= '0;
            shift_cnt_q <= 5'd0;
            shift_op_q  <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            br_q        <= br_d;
`ifdef ALU_SERIAL_SHIFT_EN
            shift_val_q <= shift_val_d;
            shift_cnt_q <= shift_cnt_d;
            shift_op_q  <= shift_op_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ex_unit.sv
// Self-checking bench for alu_ex_unit: directed corner cases, then randomized traffic against a reference model.
module tb_alu_ex_unit;

`ifdef ALU_SERIAL_SHIFT_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  Operation;
    logic [31:0] SrcA, SrcB;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        BrTaken;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] res;
        logic        br;
    } exp_t;
    exp_t exp_q[$];

    alu_ex_unit #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .BrTaken(BrTaken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic slt_model(input logic [31:0] a, input logic [31:0] b);
        // Flipping the sign bit maps two's complement order onto unsigned order.
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic br);
        int k;
        k  = int'(b[4:0]);
        r  = 32'd0;
        br = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0100: r = a << k;
            4'b0101: r = a >> k;
            4'b0111: r = a[31] ? ~((~a) >> k) : (a >> k);
            4'b1100: r = {31'd0, slt_model(a, b)};
            4'b1000: br = (a == b);
            4'b1110: br = (a != b);
            4'b1111: br = slt_model(a, b);
            default: ;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] op, input logic [31:0] b);
        bit is_sh;
        is_sh = (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0111);
        if (SERIAL && is_sh && b[4:0] != 5'd0) return 1 + int'(b[4:0]);
        return 1;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_op();
        logic [3:0] codes [11];
        int i;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0101,
                  4'b0111, 4'b1100, 4'b1000, 4'b1110, 4'b1111};
        i = $urandom_range(0, 13);
        if (i >= 11) return 4'($urandom_range(0, 15));
        return codes[i];
    endfunction

    // Issues one op, waits for its result, checks latency/value, holds it for `hold` cycles, then drains it.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eb;
        int          n, w;
        model(op, a, b, er, eb);
        in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
        #1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk); #1; w++;
        end
        if (w >= 100) check({tag, "_accept_timeout"}, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 1;
        while (!out_valid && n < 100) begin
            check({tag, "_busy_in_ready"}, in_ready, 0);
            @(negedge clk); #1; n++;
        end
        check({tag, "_latency"}, n, exp_latency(op, b));
        check({tag, "_result"}, ALUResult, er);
        check({tag, "_brtaken"}, BrTaken, eb);
        $display("op=%b A=%h B=%h -> res=%h br=%0d lat=%0d", op, a, b, ALUResult, BrTaken, n);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_result"}, ALUResult, er);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        logic [31:0] er;
        logic        eb;
        exp_t        e;
        int          guard;

        reset = 1'b1; in_valid = 1'b0; Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", ALUResult, 0);
        check("rst_br", BrTaken, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
        do_op("blt_neg", 4'b1111, 32'hFFFF_FFFF, 32'h1, 0);
        do_op("slt_neg", 4'b1100, 32'hFFFF_FFFF, 32'h1, 0);
        do_op("bne_eq", 4'b1110, 32'd5, 32'd5, 0);
        do_op("beq_eq", 4'b1000, 32'd5, 32'd5, 0);
        do_op("nop_1010", 4'b1010, 32'd3, 32'd3, 0);
        do_op("sra_4", 4'b0111, 32'h8000_0000, 32'd4, 0);
        do_op("sll_0", 4'b0100, 32'h1234_5678, 32'd0, 0);
        do_op("srl_31", 4'b0101, 32'h8000_0000, 32'd31, 0);

        // SUB held three cycles, then drain and new accept in the same cycle.
        do_op("sub_hold", 4'b0110, 32'd10, 32'd3, 3);
        in_valid = 1'b1; Operation = 4'b0110; SrcA = 32'd10; SrcB = 32'd3;
        @(negedge clk); in_valid = 1'b0; #1;
        check("b2b_first_valid", out_valid, 1);
        check("b2b_first_result", ALUResult, 32'd7);
        out_ready = 1'b1; in_valid = 1'b1; Operation = 4'b0000; SrcA = 32'hF0F0_F0F0; SrcB = 32'hFF00_FF00;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check("b2b_second_valid", out_valid, 1);
        check("b2b_second_result", ALUResult, 32'hF000_F000);
        @(negedge clk); out_ready = 1'b0; #1;
        check("b2b_drained", out_valid, 0);

        // Flush two cycles into a long shift.
        in_valid = 1'b1; Operation = 4'b0100; SrcA = $urandom | 32'h1; SrcB = 32'd31;
        #1;
        check("fl_in_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; #1;
        check("fl_valid_c1", out_valid, !SERIAL);
        @(negedge clk); #1;
        check("fl_valid_c2", out_valid, !SERIAL);
        flush = 1'b1;
        #1;
        check("fl_in_ready_during", in_ready, 0);
        @(negedge clk); flush = 1'b0; #1;
        check("fl_after_valid", out_valid, 0);
        check("fl_after_in_ready", in_ready, 1);
        watch_no_valid("fl_no_result", 40);
        do_op("or_after_flush", 4'b0001, 32'hF0, 32'h0F, 0);

        // Reset in the middle of a shift.
        in_valid = 1'b1; Operation = 4'b0101; SrcA = 32'hDEAD_BEEF; SrcB = 32'd20;
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; #1;
        check("rmid_in_ready", in_ready, 0);
        @(negedge clk); reset = 1'b0; #1;
        check("rmid_out_valid", out_valid, 0);
        check("rmid_result", ALUResult, 0);
        check("rmid_in_ready_after", in_ready, 1);
        watch_no_valid("rmid_no_result", 40);

        for (int i = 0; i < 60; i++) begin
            do_op("rand_op", rand_op(), rand_word(), rand_word(), $urandom_range(0, 2));
        end

        // Streaming traffic with random backpressure, scored in order.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            Operation = rand_op(); SrcA = rand_word(); SrcB = rand_word();
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", ALUResult, e.res);
                    check("stream_brtaken", BrTaken, e.br);
                end
            end
            if (in_valid && in_ready) begin
                model(Operation, SrcA, SrcB, er, eb);
                e.res = er; e.br = eb;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            #1;
            if (out_valid) begin
                e = exp_q.pop_front();
                check("drain_result", ALUResult, e.res);
                check("drain_brtaken", BrTaken, e.br);
            end
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_ex_unit.md
ALU_EX_UNIT -- requirements
Module: alu_ex_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port Operation  input  4  ALU operation code from ALU controller.
REQ-007 SHALL have ports SrcA, SrcB  input  DATA_W  operands.
REQ-008 SHALL have port flush  input  1  kill in-flight and pending work.
REQ-009 SHALL have port out_valid  output  1  result held valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port ALUResult  output  DATA_W  registered result.
REQ-012 SHALL have port BrTaken  output  1  registered branch condition.

Function
REQ-013 SHALL decode Operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 SLL, 0101 SRL, 0111 SRA, 1100 SLT, 1000 BEQ, 1110 BNE, 1111 BLT.
REQ-014 SHALL treat any other code as NOP: ALUResult=0, BrTaken=0, normal latency.
REQ-015 SHALL use SrcB[4:0] as shift amount; ADD/SUB wrap modulo 2^DATA_W.
REQ-016 SLT SHALL return 1 if SrcA<SrcB signed, else 0, zero-extended.
REQ-017 Branch ops SHALL set BrTaken (BEQ A==B; BNE A!=B; BLT signed A<B) and ALUResult=0; non-branch ops SHALL set BrTaken=0.
REQ-018 Accept occurs when in_valid && in_ready && !flush; operands and Operation captured at accept.
REQ-019 FSM states IDLE, SHIFT; in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-020 Non-shift op accepted in cycle N SHALL present out_valid=1 with result from cycle N+1.
REQ-021 out_valid SHALL stay high and ALUResult/BrTaken stable until out_valid && out_ready.
REQ-022 Result drain and new accept in the same cycle SHALL be allowed: throughput one op/cycle for single-cycle ops.
REQ-023 flush SHALL, next edge, clear out_valid, abort any shift, return to IDLE; no accept that cycle.
REQ-024 flush with reset SHALL behave as reset.

Reset
REQ-025 On reset: state=IDLE, out_valid=0, ALUResult=0, BrTaken=0, shift counter=0.
REQ-026 in_ready SHALL be 0 during the reset cycle and 1 the first cycle after.
REQ-027 reset mid-shift SHALL discard the operation; no result is ever presented for it.

Configuration
REQ-028 Macro ALU_SERIAL_SHIFT_EN SHALL select shifter implementation.
REQ-029 Defined: shifts iterate one bit per cycle in SHIFT; shift accepted at N with amount k>0 SHALL give out_valid at N+1+k; k=0 SHALL give N+1 without entering SHIFT.
REQ-030 Defined: in_ready SHALL be 0 while in SHIFT; SRA SHALL replicate the sign bit every step.
REQ-031 Undefined: all shifts single-cycle barrel shift per REQ-020; SHIFT state unused.

Verification
REQ-032 reset, then ADD A=0x7FFFFFFF B=1 -> next cycle out_valid=1, ALUResult=0x80000000, BrTaken=0.
REQ-033 BLT A=0xFFFFFFFF B=1, and SLT same operands -> BrTaken=1 / ALUResult=1; BNE A=B=5 -> BrTaken=0.
REQ-034 out_ready=0 for 3 cycles after SUB 10-3 -> ALUResult=7 held stable, in_ready=0; out_ready=1 with new in_valid -> drain and accept same cycle.
REQ-035 With ALU_SERIAL_SHIFT_EN: SRA A=0x80000000 B=4 accepted at N -> in_ready=0 N+1..N+4, out_valid at N+5, ALUResult=0xF8000000; without macro -> out_valid at N+1.
REQ-036 flush asserted 2 cycles into SLL B=31 (macro defined) -> out_valid never asserts for it, in_ready=1 next cycle, following OR 0xF0|0x0F -> 0xFF.
REQ-037 Operation=1010 A=B=3 -> ALUResult=0, BrTaken=0, out_valid next cycle.
